// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg: shared types and default widths for the FIR TDM scheduler
package fir_sched_pkg;
  localparam int DW_DEF = 16;
  localparam int OW_DEF = 24;
  typedef enum logic [1:0] {IDLE, SEND_L, SEND_R, GAP} state_t;
  typedef struct packed {
    logic [DW_DEF-1:0] left;
    logic [DW_DEF-1:0] right;
  } pair_t;
endpackage

// File: rtl/pair_fifo.sv
// pair_fifo: small synchronous FIFO with extra-bit pointers; clr empties it
module pair_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !clr) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/fir_tdm_scheduler.sv
// fir_tdm_scheduler: time-multiplexes one FIR between L/R and rebuilds stereo pairs
// Define FIR_SCHED_STATS_EN to add saturating drop / framing-error counters
module fir_tdm_scheduler
  import fir_sched_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF,
  parameter int FIFO_DEPTH = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic          AMCLK_i,
  input  logic          nARST,
  input  logic          enable_i,
  input  logic          clr_i,
  input  logic [DW-1:0] in_left_i,
  input  logic [DW-1:0] in_right_i,
  input  logic          in_valid_i,
  output logic [DW-1:0] fir_sink_data_o,
  output logic          fir_sink_valid_o,
  output logic          fir_sink_sop_o,
  output logic          fir_sink_eop_o,
  input  logic [OW-1:0] fir_source_data_i,
  input  logic          fir_source_valid_i,
  input  logic          fir_source_sop_i,
  input  logic          fir_source_eop_i,
  output logic [OW-1:0] out_left_o,
  output logic [OW-1:0] out_right_o,
  output logic          out_valid_o,
  output logic          overflow_o,
  output logic          seq_err_o
`ifdef FIR_SCHED_STATS_EN
  ,
  output logic [15:0]   drop_cnt_o,
  output logic [15:0]   seq_err_cnt_o
`endif
);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_t state, state_n;
  logic [3:0] gap_cnt;
  logic [2*DW-1:0] head, cur;
  logic [DW-1:0] data_n;
  logic [OW-1:0] held;
  logic full, empty, start, pop, push, drop;
  logic got_left, l_beat, r_beat, seq_evt;
  assign start = !empty && enable_i;
  assign push = in_valid_i && enable_i && (!full || pop);
  assign drop = in_valid_i && enable_i && full && !pop;
  pair_fifo #(.W(2*DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(AMCLK_i), .rst_n(nARST), .clr(!enable_i), .push(push), .pop(pop),
    .wdata({in_left_i, in_right_i}), .rdata(head), .full(full), .empty(empty)
  );
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = start ? SEND_L : IDLE;
      SEND_L:  state_n = SEND_R;
      SEND_R:  state_n = GAP_CYCLES > 0 ? GAP : start ? SEND_L : IDLE;
      GAP:     state_n = gap_cnt != 0 ? GAP : start ? SEND_L : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // SEND_L is only ever entered through a start decision, so entering it is the pop
  assign pop = state_n == SEND_L;
  assign data_n = state_n == SEND_L ? head[2*DW-1:DW] : state_n == SEND_R ? cur[DW-1:0] : '0;
  always_ff @(posedge AMCLK_i or negedge nARST)
    if (!nARST) begin
      state <= IDLE;
      gap_cnt <= '0;
      cur <= '0;
      fir_sink_data_o <= '0;
      fir_sink_valid_o <= 1'b0;
      fir_sink_sop_o <= 1'b0;
      fir_sink_eop_o <= 1'b0;
    end else begin
      state <= state_n;
      gap_cnt <= state_n == GAP ? (state == GAP ? gap_cnt - 1'b1 : GAP_LOAD) : '0;
      if (pop) cur <= head;
      fir_sink_data_o <= data_n;
      fir_sink_valid_o <= state_n == SEND_L || state_n == SEND_R;
      fir_sink_sop_o <= state_n == SEND_L;
      fir_sink_eop_o <= state_n == SEND_R;
    end
  assign l_beat = fir_source_sop_i && !fir_source_eop_i;
  assign r_beat = !fir_source_sop_i && fir_source_eop_i;
  assign seq_evt = fir_source_valid_i &&
                   (fir_source_sop_i == fir_source_eop_i || (fir_source_sop_i ? got_left : !got_left));
  always_ff @(posedge AMCLK_i or negedge nARST)
    if (!nARST) begin
      held <= '0;
      got_left <= 1'b0;
      out_left_o <= '0;
      out_right_o <= '0;
      out_valid_o <= 1'b0;
      overflow_o <= 1'b0;
      seq_err_o <= 1'b0;
    end else begin
      out_valid_o <= 1'b0;
      if (fir_source_valid_i) begin
        if (l_beat) begin
          held <= fir_source_data_i;
          got_left <= 1'b1;
        end else if (r_beat && got_left) begin
          out_left_o <= held;
          out_right_o <= fir_source_data_i;
          out_valid_o <= 1'b1;
          got_left <= 1'b0;
        end else if (!r_beat) got_left <= 1'b0;
      end
      overflow_o <= drop || (overflow_o && !clr_i);
      seq_err_o <= seq_evt || (seq_err_o && !clr_i);
    end
`ifdef FIR_SCHED_STATS_EN
  always_ff @(posedge AMCLK_i or negedge nARST)
    if (!nARST) begin
      drop_cnt_o <= '0;
      seq_err_cnt_o <= '0;
    end else begin
      drop_cnt_o <= clr_i ? 16'(drop) : drop_cnt_o + 16'(drop && drop_cnt_o != 16'hFFFF);
      seq_err_cnt_o <= clr_i ? 16'(seq_evt) : seq_err_cnt_o + 16'(seq_evt && seq_err_cnt_o != 16'hFFFF);
    end
`endif
endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// tb_fir_tdm_scheduler: directed self-checking bench for the FIR TDM scheduler
`timescale 1ns/1ps
module tb_fir_tdm_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, clr = 1'b0, in_valid = 1'b0;
  logic [15:0] in_left = '0, in_right = '0;
  logic [15:0] sink_data;
  logic sink_valid, sink_sop, sink_eop;
  logic [23:0] src_data, man_data = '0, echo_data = '0;
  logic src_valid, src_sop, src_eop;
  logic man_valid = 1'b0, man_sop = 1'b0, man_eop = 1'b0;
  logic echo_valid = 1'b0, echo_sop = 1'b0, echo_eop = 1'b0, echo = 1'b1;
  logic [23:0] out_left, out_right;
  logic out_valid, overflow, seq_err;
`ifdef FIR_SCHED_STATS_EN
  logic [15:0] drop_cnt, seq_err_cnt;
`endif
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {int c; logic sop; logic eop; logic [15:0] d;} beat_t;
  beat_t beats[$];

  fir_tdm_scheduler dut (
    .AMCLK_i(clk), .nARST(rst_n), .enable_i(enable), .clr_i(clr),
    .in_left_i(in_left), .in_right_i(in_right), .in_valid_i(in_valid),
    .fir_sink_data_o(sink_data), .fir_sink_valid_o(sink_valid),
    .fir_sink_sop_o(sink_sop), .fir_sink_eop_o(sink_eop),
    .fir_source_data_i(src_data), .fir_source_valid_i(src_valid),
    .fir_source_sop_i(src_sop), .fir_source_eop_i(src_eop),
    .out_left_o(out_left), .out_right_o(out_right), .out_valid_o(out_valid),
    .overflow_o(overflow), .seq_err_o(seq_err)
`ifdef FIR_SCHED_STATS_EN
    , .drop_cnt_o(drop_cnt), .seq_err_cnt_o(seq_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // one-cycle echo FIR: {8'h00, sample} with the framing markers passed through
  always @(posedge clk) begin
    cyc <= cyc + 1;
    echo_data <= {8'h00, sink_data};
    echo_valid <= sink_valid;
    echo_sop <= sink_sop;
    echo_eop <= sink_eop;
  end
  assign src_data = echo ? echo_data : man_data;
  assign src_valid = echo ? echo_valid : man_valid;
  assign src_sop = echo ? echo_sop : man_sop;
  assign src_eop = echo ? echo_eop : man_eop;

  always @(negedge clk)
    if (sink_valid) beats.push_back('{cyc, sink_sop, sink_eop, sink_data});

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic found;
    repeat (3) tick();
    chk("rst_flags", {sink_valid, sink_sop, sink_eop, out_valid, overflow, seq_err}, 0);
    chk("rst_data", {sink_data, out_left, out_right}, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (2) tick();
    // single pair: sop at cycle 2, eop at cycle 3, reassembled pair two cycles later
    in_left = 16'h1234; in_right = 16'hABCD; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    chk("t1_cycle1", sink_valid, 0); tick();
    chk("t1_sop", {sink_valid, sink_sop, sink_eop, sink_data}, {3'b110, 16'h1234}); tick();
    chk("t1_eop", {sink_valid, sink_sop, sink_eop, sink_data}, {3'b101, 16'hABCD}); tick();
    chk("t1_gap", {sink_valid, out_valid}, 0); tick();
    chk("t1_out", {out_valid, out_left, out_right}, {1'b1, 24'h001234, 24'h00ABCD}); tick();
    chk("t1_hold", {out_valid, out_left, out_right}, {1'b0, 24'h001234, 24'h00ABCD});
    repeat (6) tick();
    // three consecutive pairs fit
    base = beats.size();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_left = 16'(16'h1111 * (2 * k + 1));
      in_right = 16'(16'h1111 * (2 * k + 2));
      tick();
    end
    in_valid = 1'b0;
    repeat (20) tick();
    chk("t2_count", beats.size() - base, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t2_beat%0d", i), {beats[base+i].sop, beats[base+i].eop, beats[base+i].d},
          {(i % 2 == 0) ? 2'b10 : 2'b01, 16'(16'h1111 * (i + 1))});
    chk("t2_spacing", beats[base+2].c - beats[base].c, 4);
    chk("t2_ovf", overflow, 0);
    // four consecutive pairs: the fourth is dropped
    base = beats.size();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_left = 16'(16'h0101 * (2 * k + 1));
      in_right = 16'(16'h0101 * (2 * k + 2));
      tick();
    end
    in_valid = 1'b0;
    repeat (20) tick();
    chk("t3_count", beats.size() - base, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t3_beat%0d", i), beats[base+i].d, 16'(16'h0101 * (i + 1)));
    chk("t3_ovf", overflow, 1);
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("t3_clr", overflow, 0);
    repeat (4) tick();
    // enable dropped during SEND_L
    base = beats.size();
    in_left = 16'hAAAA; in_right = 16'hBBBB; in_valid = 1'b1; tick();
    in_left = 16'hCCCC; in_right = 16'hDDDD; tick();
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++)
      if (sink_sop) found = 1'b1; else tick();
    chk("t4_sop_seen", found, 1);
    chk("t4_sop_data", sink_data, 16'hAAAA);
    enable = 1'b0; tick();
    chk("t4_eop", {sink_valid, sink_sop, sink_eop, sink_data}, {3'b101, 16'hBBBB});
    in_left = 16'h0F0F; in_valid = 1'b1; repeat (3) tick();
    in_valid = 1'b0; repeat (6) tick();
    enable = 1'b1; repeat (12) tick();
    chk("t4_count", beats.size() - base, 2);
    chk("t4_ovf", overflow, 0);
    // framing errors on the FIR output side
    echo = 1'b0; tick();
    man_valid = 1'b1; man_sop = 1'b0; man_eop = 1'b1; man_data = 24'h000777; tick();
    man_valid = 1'b0;
    chk("t5_lone_eop", {seq_err, out_valid}, 2'b10);
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("t5_clr", seq_err, 0);
    man_valid = 1'b1; man_sop = 1'b1; man_eop = 1'b0; man_data = 24'h111111; tick();
    man_data = 24'h222222; tick();
    chk("t5_dbl_sop", seq_err, 1);
    man_sop = 1'b0; man_eop = 1'b1; man_data = 24'h333333; tick();
    man_valid = 1'b0;
    chk("t5_out", {out_valid, out_left, out_right}, {1'b1, 24'h222222, 24'h333333});
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("t5_clr2", seq_err, 0);
    man_valid = 1'b1; man_sop = 1'b1; man_eop = 1'b0; man_data = 24'h444444; tick();
    man_eop = 1'b1; clr = 1'b1; tick();
    clr = 1'b0;
    chk("t5_set_wins", {seq_err, out_valid}, 2'b10);
    man_sop = 1'b0; man_eop = 1'b1; man_data = 24'h555555; tick();
    man_valid = 1'b0;
    chk("t5_after_drop", {out_valid, out_left}, {1'b0, 24'h222222});
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("t5_clr3", seq_err, 0);
    repeat (4) tick();
    // asynchronous reset while SEND_R and out_valid are both high
    in_left = 16'h0A0A; in_right = 16'h0B0B; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    man_valid = 1'b1; man_sop = 1'b1; man_eop = 1'b0; man_data = 24'hC0FFEE; tick();
    chk("t6_sop", {sink_valid, sink_sop, sink_data}, {2'b11, 16'h0A0A});
    man_sop = 1'b0; man_eop = 1'b1; man_data = 24'hBEEF00; tick();
    man_valid = 1'b0;
    chk("t6_pre", {sink_eop, out_valid, out_left}, {2'b11, 24'hC0FFEE});
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_sink", {sink_valid, sink_sop, sink_eop, sink_data}, 0);
    chk("t6_async_out", {out_valid, out_left, out_right}, 0);
    tick();
    rst_n = 1'b1; tick();
    in_left = 16'h5A5A; in_right = 16'hA5A5; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    chk("t6_lat1", sink_valid, 0); tick();
    chk("t6_lat_sop", {sink_valid, sink_sop, sink_eop, sink_data}, {3'b110, 16'h5A5A}); tick();
    chk("t6_lat_eop", {sink_valid, sink_sop, sink_eop, sink_data}, {3'b101, 16'hA5A5});
    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
